// File: rtl/subr4u_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : subr4u_serial_if
// Description : Operand/result valid-ready bundle for the bit-serial
//               unsigned subtractor. master = producer/consumer side,
//               slave = subtractor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface subr4u_serial_if #(
    parameter int WIDTH = 4
);
    // Operand channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, d, bout, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, d, bout, zero
    );
endinterface
`default_nettype wire

// File: rtl/subr4u_serial.sv
`default_nettype none
// ============================================================================
// Module      : subr4u_serial
// Description : Bit-serial unsigned subtractor, D = A - B mod 2^WIDTH with
//               borrow-out and zero flag. One full-subtractor cell is reused
//               for WIDTH cycles, LSB first. Valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module subr4u_serial #(
    parameter int WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    subr4u_serial_if.slave    bus
);

    localparam int                CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;
    logic               zero_q, zero_d;

    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_abit;
    logic               w_bbit;
    logic               w_diff_bit;
    logic               w_br_next;

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle datapath strobes
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        w_shift  = 1'b0;
        w_last   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (cnt_q == C_LAST) begin
                    w_last  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The single reused full-subtractor cell working on bit cnt
    assign w_abit     = a_q[cnt_q];
    assign w_bbit     = b_q[cnt_q];
    assign w_diff_bit = w_abit ^ w_bbit ^ br_q;
    assign w_br_next  = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & br_q);

    // Datapath next-state: operand capture, bit write-back, final flags
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        d_d    = d_q;
        bout_d = bout_q;
        zero_d = zero_q;
        if (w_accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            br_d  = 1'b0;
            cnt_d = '0;
        end
        if (w_shift) begin
            d_d[cnt_q] = w_diff_bit;
            br_d       = w_br_next;
            // Hold the counter on the final bit so it never wraps mid-operation
            cnt_d      = w_last ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (w_last) begin
            bout_d = w_br_next;
            zero_d = (d_d == '0) & ~w_br_next;
        end
    end

    // Datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            d_q    <= d_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
        end
    end

    // Handshake flags decode straight from the state register; results are registers
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_subr4u_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_subr4u_serial
// Description : Scoreboard bench for subr4u_serial. The driver pushes the
//               arithmetic expectation on every accept; a monitor pops and
//               compares on every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subr4u_serial;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    subr4u_serial_if #(.WIDTH(WIDTH)) bus ();

    subr4u_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             zero;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   hs_cnt   = 0;
    int   last_acc = 0;
    int   or_mode  = 0;   // 0: out_ready low, 1: high, 2: random
    logic prev_ov  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready has a single owner; the main sequence only selects the mode
    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on each handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !prev_ov) begin
                check("result_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) check("latency", cyc - sb[0].acc_cyc, WIDTH);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_handshake", int'(bus.out_valid), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("d",    int'(bus.d),    int'(mon_e.d));
                    check("bout", int'(bus.bout), int'(mon_e.bout));
                    check("zero", int'(bus.zero), int'(mon_e.zero));
                    hs_cnt++;
                end
            end
        end
        prev_ov = bus.out_valid;
    end

    // Drive one operand pair and push the arithmetic expectation on accept
    task automatic send(input int a, input int b, input bit keep_valid);
        int   waited = 0;
        exp_t e;
        bus.a        = WIDTH'(a);
        bus.b        = WIDTH'(b);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", int'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
            return;
        end
        e.d       = WIDTH'((a - b) & MASK);
        e.bout    = (a < b);
        e.zero    = (a == b);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        last_acc  = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int n;
        int prev_acc;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        // Reset state
        #2;
        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_d",         int'(bus.d),         0);
        check("rst_bout",      int'(bus.bout),      0);
        check("rst_zero",      int'(bus.zero),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        or_mode = 1;
        repeat (2) @(posedge clk);
        #1;

        // Directed arithmetic cases
        send(9, 3, 0);
        wait_drain();
        check("in_ready_after_hs", int'(bus.in_ready), 1);
        send(3, 9, 0);
        send(0, 15, 0);
        send(15, 0, 0);
        send(5, 5, 0);
        send(0, 0, 0);
        wait_drain();

        // Backpressure: result held, operand side ignored
        or_mode = 0;
        @(posedge clk);
        #1;
        send(7, 2, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", int'(bus.out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_d",        int'(bus.d),        5);
            check("bp_bout",     int'(bus.bout),     0);
            check("bp_zero",     int'(bus.zero),     0);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        h0 = hs_cnt;
        or_mode = 1;
        n = 0;
        while (bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_released",  int'(bus.out_valid), 0);
        check("bp_in_ready2", int'(bus.in_ready),  1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_handshake", hs_cnt - h0, 1);

        // Asynchronous reset while in SHIFT with cnt == 2
        send(11, 6, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("mid_rst_in_ready",  int'(bus.in_ready),  1);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_d",         int'(bus.d),         0);
        check("mid_rst_bout",      int'(bus.bout),      0);
        check("mid_rst_zero",      int'(bus.zero),      0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(12, 7, 0);
        wait_drain();

        // Random operands with random idle gaps and random backpressure
        or_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();

        // Exhaustive, back-to-back, with fixed operation period
        or_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        prev_acc = 0;
        for (int i = 0; i < 256; i++) begin
            send(i >> WIDTH, i & MASK, i != 255);
            if (i > 0) check("period", last_acc - prev_acc, WIDTH + 2);
            prev_acc = last_acc;
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subr4u_serial.md
# subr4u_serial

Bit-serial unsigned 4-bit subtractor with borrow-out. It is the inverse-operation companion to the 4-bit unsigned adder family. It computes D = A − B (mod 2^WIDTH) plus a borrow flag, one bit per clock, LSB first. Operands enter and results leave through valid/ready handshakes, so the block can sit between registered pipeline stages of the arithmetic datapath. One ripple cell is reused over WIDTH cycles, which keeps the fault-exposed combinational area minimal.

## Interface
- WIDTH, 4, operand and difference width in bits (≥2); all counts below scale with it.
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  d/bout/zero hold a completed result.
- out_ready  input  1  downstream accepts the result.
- d  output  WIDTH  difference, A − B mod 2^WIDTH.
- bout  output  1  borrow-out, 1 iff A < B.
- zero  output  1  1 iff A == B, i.e. d == 0 and bout == 0.

## Operation
- State machine has three states: IDLE, SHIFT, DONE. The reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid & in_ready at an edge: latch a→A_r and b→B_r, clear the borrow register br=0, set the bit counter cnt=0, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge processes bit i=cnt:
    - d_r[i] = A_r[i] ^ B_r[i] ^ br.
    - br ← (~A_r[i] & B_r[i]) | (~(A_r[i] ^ B_r[i]) & br).
    - cnt ← cnt+1.
  - On the edge with cnt==WIDTH−1: write the final bit, set bout_r to the new br, go to DONE.
  - cnt is ⌈log2 WIDTH⌉ bits wide. It never wraps inside an operation and is cleared on each accept.
- DONE:
  - out_valid=1 and in_ready=0.
  - d, bout and zero are held stable until the handshake completes.
  - When out_valid & out_ready at an edge, go to IDLE.
- d, bout and zero are driven from registers only; no combinational path from inputs to outputs.
- zero is registered alongside bout. It is computed as (d_r==0) & ~bout.
- a and b are sampled only on the accept edge. Changes at any other time are ignored.
- in_valid outside IDLE, and out_ready outside DONE, have no effect.
- d keeps the last result after returning to IDLE. It is undefined to consumers while out_valid=0. It is overwritten bit by bit during the next SHIFT.
- Reset mid-operation:
  - Asynchronous assertion forces IDLE at once.
  - in_ready=1, out_valid=0, d=0, bout=0, zero=0, cnt=0, br=0.
  - Any partial result is discarded. No output glitches to 1 during reset.

## Timing
- Reset values: in_ready=1, out_valid=0, d=0, bout=0, zero=0.
- Latency: accept on edge E0, bits 0..WIDTH−1 processed on E1..E_WIDTH. out_valid is high from just after E_WIDTH (4 cycles for WIDTH=4).
- Handshake completes on the edge where out_valid & out_ready are both high. out_valid drops after that edge. in_ready rises in the same cycle.
- Minimum period per operation is WIDTH+2 cycles (6 for WIDTH=4): accept, WIDTH shifts, result handshake, then back in IDLE.
- If out_ready is held high in advance, the result handshake occurs on the first DONE edge.
- The next accept is possible on the edge following the return to IDLE.
- Backpressure: DONE persists indefinitely while out_ready=0, with outputs bit-stable.
- Reset release: the first accept may occur on the first rising edge after rst_n deasserts. The rst_n deassertion is synchronised externally.

## Test plan
- Reset, then a=9, b=3, in_valid pulse, out_ready=1 → out_valid exactly 4 cycles after accept; d=6, bout=0, zero=0; in_ready back high after the handshake edge.
- a=3, b=9 → d=10 (0xA), bout=1, zero=0. Then a=0, b=15 → d=1, bout=1. Then a=15, b=0 → d=15, bout=0.
- a=5, b=5 → d=0, bout=0, zero=1. Then a=0, b=0 → d=0, zero=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises; toggle a/b and in_valid during that time.
  - Required: d, bout and zero do not change, and in_ready stays 0.
  - Raising out_ready gives exactly one handshake.
- Assert rst_n=0 asynchronously between clock edges while in SHIFT at cnt=2 → outputs zero immediately, in_ready=1. After release, a=12, b=7 → d=5, bout=0.
- Exhaustive test: all 256 (a,b) pairs back-to-back with out_ready=1 and in_valid held high.
  - Each result must match (a−b) mod 16, bout = a<b, and zero = a==b.
  - Operation period must be exactly 6 cycles.
